// File: rtl/l2_port_scheduler_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// l2_sched_pkg: shared state/op encodings for l2_port_scheduler. Rev 1.0
// ----------------------------------------------------------------------------
package l2_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RECOVER = 2'd3
  } sched_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } l2_op_t;

  localparam int DEFAULT_STARVE_LIMIT = 3;

endpackage
`default_nettype wire

// File: rtl/l2_port_scheduler_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// l2_port_scheduler_if: I$/D$/L2 signal bundle; slave = scheduler, master = environment. Rev 1.0
// ----------------------------------------------------------------------------
interface l2_port_scheduler_if #(
  parameter int WIDTH      = 256,
  parameter int ADDR_WIDTH = 32
);
  logic                  icache_read;
  logic [ADDR_WIDTH-1:0] icache_address;
  logic [WIDTH-1:0]      icache_rdata;
  logic                  icache_resp;
  logic                  dcache_read;
  logic                  dcache_write;
  logic [ADDR_WIDTH-1:0] dcache_address;
  logic [WIDTH-1:0]      dcache_wdata;
  logic [WIDTH-1:0]      dcache_rdata;
  logic                  dcache_resp;
  logic                  l2_read;
  logic                  l2_write;
  logic [ADDR_WIDTH-1:0] l2_address;
  logic [WIDTH-1:0]      l2_wdata;
  logic [WIDTH-1:0]      l2_rdata;
  logic                  l2_resp;

  modport slave (
    input  icache_read, icache_address, dcache_read, dcache_write,
           dcache_address, dcache_wdata, l2_rdata, l2_resp,
    output icache_rdata, icache_resp, dcache_rdata, dcache_resp,
           l2_read, l2_write, l2_address, l2_wdata
  );

  modport master (
    output icache_read, icache_address, dcache_read, dcache_write,
           dcache_address, dcache_wdata, l2_rdata, l2_resp,
    input  icache_rdata, icache_resp, dcache_rdata, dcache_resp,
           l2_read, l2_write, l2_address, l2_wdata
  );
endinterface
`default_nettype wire

// File: rtl/l2_port_scheduler_starve_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// starve_counter: saturating 0..STARVE_LIMIT counter with inc/clr and at_limit. Rev 1.0
// ----------------------------------------------------------------------------
module starve_counter
  import l2_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  localparam int             CW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIM)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == LIM);
endmodule
`default_nettype wire

// File: rtl/l2_port_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// l2_port_scheduler: D-priority L2 port arbiter with bounded I starvation;
// L2_SCHED_PERF_EN adds grant/conflict performance counters. Rev 1.0
// ----------------------------------------------------------------------------
module l2_port_scheduler
  import l2_sched_pkg::*;
#(
  parameter int WIDTH        = 256,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                 clk,
  input  logic                 rst,
  l2_port_scheduler_if.slave   bus
`ifdef L2_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_i_grants,
  output logic [31:0]          perf_d_grants,
  output logic [31:0]          perf_conflict_cycles
`endif
);
  sched_state_t          state, state_next;
  l2_op_t                op;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic                  i_pend, d_pend, grant_i, grant_d, at_limit, busy;

  assign i_pend = bus.icache_read;
  assign d_pend = bus.dcache_read | bus.dcache_write;

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (i_pend && (!d_pend || at_limit)) begin
          grant_i    = 1'b1;
          state_next = SERVE_I;
        end else if (d_pend) begin
          grant_d    = 1'b1;
          state_next = SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.l2_resp) state_next = RECOVER;
      end
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op      <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_next;
      if (grant_i) begin
        addr_q <= bus.icache_address;
        op     <= OP_READ;
      end else if (grant_d) begin
        addr_q  <= bus.dcache_address;
        wdata_q <= bus.dcache_wdata;
        op      <= bus.dcache_write ? OP_WRITE : OP_READ;
      end
    end
  end

  starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (grant_d & i_pend),
    .clr      (grant_i),
    .at_limit (at_limit)
  );

  // Request drops in the resp cycle so L2 never sees a second request edge.
  assign busy         = ((state == SERVE_I) || (state == SERVE_D)) && !bus.l2_resp;
  assign bus.l2_read  = busy && (op == OP_READ);
  assign bus.l2_write = busy && (op == OP_WRITE);
  assign bus.l2_address = addr_q;
  assign bus.l2_wdata   = wdata_q;
  assign bus.icache_resp  = (state == SERVE_I) && bus.l2_resp;
  assign bus.dcache_resp  = (state == SERVE_D) && bus.l2_resp;
  assign bus.icache_rdata = bus.l2_rdata;
  assign bus.dcache_rdata = bus.l2_rdata;

`ifdef L2_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_i_grants        <= '0;
      perf_d_grants        <= '0;
      perf_conflict_cycles <= '0;
    end else begin
      if (grant_i) perf_i_grants <= perf_i_grants + 32'd1;
      if (grant_d) perf_d_grants <= perf_d_grants + 32'd1;
      if ((state == IDLE) && i_pend && d_pend)
        perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
    end
  end
`endif

  a_no_rd_wr: assert property (@(posedge clk) disable iff (rst)
    !(bus.l2_read && bus.l2_write));
  a_i_held: assert property (@(posedge clk) disable iff (rst)
    (state == SERVE_I) |-> bus.icache_read);
  a_d_held: assert property (@(posedge clk) disable iff (rst)
    (state == SERVE_D) |-> (bus.dcache_read || bus.dcache_write));
endmodule
`default_nettype wire

// File: tb/tb_l2_port_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_l2_port_scheduler: vector table, corner sequences and random traffic vs. a grant model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_l2_port_scheduler;
  import l2_sched_pkg::*;

  localparam int WIDTH = 256;
  localparam int AW    = 32;
  localparam int LIMIT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_port_scheduler_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

`ifdef L2_SCHED_PERF_EN
  logic [31:0] perf_i, perf_d, perf_c;
`endif

  l2_port_scheduler #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef L2_SCHED_PERF_EN
    ,
    .perf_i_grants        (perf_i),
    .perf_d_grants        (perf_d),
    .perf_conflict_cycles (perf_c)
`endif
  );

  typedef struct {
    bit              i;
    bit              d;
    bit              dw;
    logic [AW-1:0]   ia;
    logic [AW-1:0]   da;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd;
    int              lat;
    bit              exp_d;
  } vec_t;

  vec_t tbl[10];
  int checks = 0;
  int errors = 0;
  int exp_pi, exp_pd, exp_pc;

  task automatic chk(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_line();
    logic [WIDTH-1:0] v;
    for (int k = 0; k < WIDTH / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.icache_read    = 1'b0;
    bus.icache_address = '0;
    bus.dcache_read    = 1'b0;
    bus.dcache_write   = 1'b0;
    bus.dcache_address = '0;
    bus.dcache_wdata   = '0;
    bus.l2_rdata       = '0;
    bus.l2_resp        = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_pi = 0; exp_pd = 0; exp_pc = 0;
  endtask

  // One full transaction starting at a negedge with the DUT idle; ends at the
  // negedge of the following IDLE cycle with the served request dropped.
  task automatic txn(input bit ireq, input bit dreq, input bit dwr,
                     input logic [AW-1:0] ia, input logic [AW-1:0] da,
                     input logic [WIDTH-1:0] wd, input logic [WIDTH-1:0] rd,
                     input int lat, input bit exp_d, input bit mutate, input string tag);
    bit exp_rd, exp_wr;
    logic [AW-1:0] exp_a;
    bus.icache_read    = ireq;
    bus.icache_address = ia;
    bus.dcache_read    = dreq && !dwr;
    bus.dcache_write   = dreq && dwr;
    bus.dcache_address = da;
    bus.dcache_wdata   = wd;
    if (exp_d) exp_pd++; else exp_pi++;
    if (ireq && dreq) exp_pc++;
    exp_rd = exp_d ? !dwr : 1'b1;
    exp_wr = exp_d && dwr;
    exp_a  = exp_d ? da : ia;
    @(posedge clk); @(negedge clk);
    chk({tag, "_op"}, {bus.l2_read, bus.l2_write}, {exp_rd, exp_wr});
    chk({tag, "_addr"}, bus.l2_address, exp_a);
    chk({tag, "_noresp"}, {bus.icache_resp, bus.dcache_resp}, 2'b00);
    if (exp_wr) chk({tag, "_wdata"}, bus.l2_wdata, wd);
    for (int k = 0; k < lat; k++) begin
      if (mutate && exp_d) bus.dcache_address = $urandom;
      @(posedge clk); @(negedge clk);
      chk({tag, "_hold_op"}, {bus.l2_read, bus.l2_write}, {exp_rd, exp_wr});
      chk({tag, "_hold_addr"}, bus.l2_address, exp_a);
      if (exp_wr) chk({tag, "_hold_wdata"}, bus.l2_wdata, wd);
    end
    bus.l2_rdata = rd;
    bus.l2_resp  = 1'b1;
    #1;
    chk({tag, "_resp"}, {bus.icache_resp, bus.dcache_resp}, {!exp_d, exp_d});
    chk({tag, "_rdata"}, exp_d ? bus.dcache_rdata : bus.icache_rdata, rd);
    chk({tag, "_op_off"}, {bus.l2_read, bus.l2_write}, 2'b00);
    @(posedge clk); @(negedge clk);
    bus.l2_resp = 1'b0;
    if (exp_d) begin
      bus.dcache_read  = 1'b0;
      bus.dcache_write = 1'b0;
    end else begin
      bus.icache_read = 1'b0;
    end
    #1;
    chk({tag, "_recover"}, {bus.l2_read, bus.l2_write, bus.icache_resp, bus.dcache_resp}, 4'b0000);
    @(posedge clk); @(negedge clk);
    chk({tag, "_idle_gap"}, {bus.l2_read, bus.l2_write}, 2'b00);
  endtask

  initial begin
    bit ip, dp, dw, exp_d;
    logic [AW-1:0] ia, da;
    logic [WIDTH-1:0] wd;
    int cnt;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0, {WIDTH{1'b0}}, {32{8'hA5}}, 5, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h8000_0040, {WIDTH{1'b1}}, {32{8'h3C}}, 3, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h2000, 32'h9000, {WIDTH{1'b0}}, {32{8'h11}}, 1, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h2040, 32'h9040, {8{32'hDEADBEEF}}, {32{8'h22}}, 0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h9080, {WIDTH{1'b0}}, {32{8'h33}}, 2, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h2080, 32'h90C0, {WIDTH{1'b0}}, {32{8'h44}}, 1, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h20C0, 32'h9100, {8{32'h0F0F0F0F}}, {32{8'h55}}, 2, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h2100, 32'h9140, {8{32'h12345678}}, {32{8'h66}}, 0, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 32'h2140, 32'h0, {WIDTH{1'b0}}, {32{8'h77}}, 1, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 32'h2180, 32'h9180, {WIDTH{1'b0}}, {32{8'h88}}, 3, 1'b1};

    rst = 1'b1;
    idle_inputs();
    #1;
    chk("reset_ops", {bus.l2_read, bus.l2_write, bus.icache_resp, bus.dcache_resp}, 4'b0000);
    chk("reset_addr", bus.l2_address, '0);
    chk("reset_wdata", bus.l2_wdata, '0);
    do_reset();

    for (int t = 0; t < 10; t++)
      txn(tbl[t].i, tbl[t].d, tbl[t].dw, tbl[t].ia, tbl[t].da, tbl[t].wd, tbl[t].rd,
          tbl[t].lat, tbl[t].exp_d, 1'b0, $sformatf("vec%0d", t));

    // Both caches requesting on every arbitration: D,D,D,I repeating.
    do_reset();
    for (int k = 0; k < 8; k++)
      txn(1'b1, 1'b1, k[0], 32'h4000 + k, 32'hC000 + k, rand_line(), rand_line(),
          1 + (k % 3), (k % 4) != 3, 1'b0, $sformatf("starve%0d", k));

    // Address change mid-SERVE_D must not disturb the captured address.
    txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h5555_0000, {WIDTH{1'b0}}, rand_line(), 4, 1'b1, 1'b1, "stable");

    // Reset in the middle of a D write while I waits.
    do_reset();
    bus.dcache_write   = 1'b1;
    bus.dcache_address = 32'h8000_0040;
    bus.dcache_wdata   = {WIDTH{1'b1}};
    @(posedge clk); @(negedge clk);
    chk("mid_pre_write", bus.l2_write, 1'b1);
    bus.icache_read    = 1'b1;
    bus.icache_address = 32'h3000;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ops", {bus.l2_read, bus.l2_write, bus.icache_resp, bus.dcache_resp}, 4'b0000);
    chk("mid_rst_addr", bus.l2_address, '0);
    chk("mid_rst_wdata", bus.l2_wdata, '0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    bus.dcache_write = 1'b0;
    exp_pi = 0; exp_pd = 0; exp_pc = 0;
    txn(1'b1, 1'b0, 1'b0, 32'h3000, 32'h0, {WIDTH{1'b0}}, rand_line(), 2, 1'b0, 1'b0, "post_rst");

    // Random traffic against a grant model of the starvation rule.
    do_reset();
    cnt = 0; ip = 0; dp = 0; dw = 0; ia = '0; da = '0; wd = '0;
    for (int it = 0; it < 150; it++) begin
      if (!ip) begin ip = bit'($urandom_range(0, 1)); ia = $urandom; end
      if (!dp) begin
        dp = bit'($urandom_range(0, 1)); dw = bit'($urandom_range(0, 1));
        da = $urandom; wd = rand_line();
      end
      if (!ip && !dp) ip = 1'b1;
      if (ip && dp) exp_d = (cnt != LIMIT);
      else          exp_d = dp;
      if (exp_d) begin
        if (ip && cnt < LIMIT) cnt++;
      end else begin
        cnt = 0;
      end
      txn(ip, dp, dw, ia, da, wd, rand_line(), $urandom_range(0, 4), exp_d,
          bit'($urandom_range(0, 1)), "rnd");
      if (exp_d) dp = 1'b0; else ip = 1'b0;
    end

`ifdef L2_SCHED_PERF_EN
    chk("perf_i", perf_i, exp_pi);
    chk("perf_d", perf_d, exp_pd);
    chk("perf_c", perf_c, exp_pc);
    do_reset();
    chk("perf_rst", {perf_i, perf_d, perf_c}, 96'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
